// File: rtl/register_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : register_file_arbiter
// Brief    : Round-robin arbiter with bounded burst lock sharing one register
//            file between two clients; returns read data with valid pulses.
// Revision : 1.0 - initial release
// ============================================================================
module register_file_arbiter #(
  parameter int DATA_WIDTH = 18,
  parameter int ADDR_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  c0_req,
  input  logic                  c0_lock,
  input  logic                  c0_write,
  input  logic [ADDR_WIDTH-1:0] c0_wr_addr,
  input  logic [DATA_WIDTH-1:0] c0_wr_data,
  input  logic [ADDR_WIDTH-1:0] c0_rd_addr1,
  input  logic [ADDR_WIDTH-1:0] c0_rd_addr2,
  input  logic                  c1_req,
  input  logic                  c1_lock,
  input  logic                  c1_write,
  input  logic [ADDR_WIDTH-1:0] c1_wr_addr,
  input  logic [DATA_WIDTH-1:0] c1_wr_data,
  input  logic [ADDR_WIDTH-1:0] c1_rd_addr1,
  input  logic [ADDR_WIDTH-1:0] c1_rd_addr2,
  output logic                  c0_gnt,
  output logic                  c1_gnt,
  output logic                  c0_rd_valid,
  output logic                  c1_rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data1,
  output logic [DATA_WIDTH-1:0] rd_data2,
  output logic                  rf_enable,
  output logic                  rf_load,
  output logic [ADDR_WIDTH-1:0] rf_reg_to_write,
  output logic [DATA_WIDTH-1:0] rf_data_to_write,
  output logic [ADDR_WIDTH-1:0] rf_reg_to_read1,
  output logic [ADDR_WIDTH-1:0] rf_reg_to_read2,
  input  logic [DATA_WIDTH-1:0] rf_data_to_read1,
  input  logic [DATA_WIDTH-1:0] rf_data_to_read2
);

  localparam logic [3:0] c_max_burst = 4'(MAX_BURST);

  logic       r_prio;
  logic       r_owner_valid;
  logic       r_owner_id;
  logic [3:0] r_burst_cnt;
  logic       r_c0_rd_valid;
  logic       r_c1_rd_valid;

  logic       w_owner_req;
  logic       w_burst_open;
  logic       w_any_gnt;
  logic       w_sel;
  logic       w_lock;

  // Grant selection; w_sel is the granted client id, meaningful with w_any_gnt.
  always_comb begin
    w_owner_req  = r_owner_id ? c1_req : c0_req;
    w_burst_open = r_owner_valid && w_owner_req && (r_burst_cnt < c_max_burst);
    w_any_gnt    = 1'b0;
    w_sel        = 1'b0;
    if (reset_n) begin
      if (w_burst_open) begin
        w_any_gnt = 1'b1;
        w_sel     = r_owner_id;
      end else if (c0_req && c1_req) begin
        w_any_gnt = 1'b1;
        w_sel     = (r_owner_valid && (r_burst_cnt == c_max_burst)) ? ~r_owner_id : r_prio;
      end else if (c0_req || c1_req) begin
        w_any_gnt = 1'b1;
        w_sel     = c1_req;
      end
    end
  end

  assign c0_gnt = w_any_gnt & ~w_sel;
  assign c1_gnt = w_any_gnt &  w_sel;
  assign w_lock = w_sel ? c1_lock : c0_lock;

  // Register file drive; idle cycles present client 0 values with enable low.
  always_comb begin
    rf_enable        = w_any_gnt;
    rf_load          = 1'b0;
    rf_reg_to_write  = '0;
    rf_data_to_write = '0;
    rf_reg_to_read1  = '0;
    rf_reg_to_read2  = '0;
    if (reset_n) begin
      if (c1_gnt) begin
        rf_load          = c1_write;
        rf_reg_to_write  = c1_wr_addr;
        rf_data_to_write = c1_wr_data;
        rf_reg_to_read1  = c1_rd_addr1;
        rf_reg_to_read2  = c1_rd_addr2;
      end else begin
        rf_load          = c0_gnt & c0_write;
        rf_reg_to_write  = c0_wr_addr;
        rf_data_to_write = c0_wr_data;
        rf_reg_to_read1  = c0_rd_addr1;
        rf_reg_to_read2  = c0_rd_addr2;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_prio        <= 1'b0;
      r_owner_valid <= 1'b0;
      r_owner_id    <= 1'b0;
      r_burst_cnt   <= 4'd0;
      r_c0_rd_valid <= 1'b0;
      r_c1_rd_valid <= 1'b0;
    end else begin
      r_c0_rd_valid <= c0_gnt;
      r_c1_rd_valid <= c1_gnt;
      if (w_any_gnt) begin
        r_prio <= ~w_sel;
        if (w_lock) begin
          r_owner_valid <= 1'b1;
          r_owner_id    <= w_sel;
          // Continuing owner counts up and saturates; a new owner starts at one.
          if (r_owner_valid && (r_owner_id == w_sel)) begin
            if (r_burst_cnt < c_max_burst) begin
              r_burst_cnt <= r_burst_cnt + 4'd1;
            end
          end else begin
            r_burst_cnt <= 4'd1;
          end
        end else begin
          r_owner_valid <= 1'b0;
          r_burst_cnt   <= 4'd0;
        end
      end else if (r_owner_valid && !w_owner_req) begin
        r_owner_valid <= 1'b0;
        r_burst_cnt   <= 4'd0;
      end
    end
  end

  assign c0_rd_valid = r_c0_rd_valid;
  assign c1_rd_valid = r_c1_rd_valid;
  assign rd_data1    = rf_data_to_read1;
  assign rd_data2    = rf_data_to_read2;

endmodule
`default_nettype wire
